// File: rtl/shift_exec_stage.sv
// RV32I shift execute stage (SLL/SRL/SRA): decode, barrel shift, registered
// valid/ready output with a one-entry skid buffer.

module shift_barrel #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic          right,
  input  logic          arith,
  output logic [N-1:0]  y
);
  logic [SW:0][N-1:0] stg;
  logic [N-1:0]       rev_in, rev_out;
  logic               fill;

  // Left shifts reuse the right-shift network by mirroring bits in and out.
  always_comb begin
    rev_in  = '0;
    rev_out = '0;
    for (int i = 0; i < N; i++) begin
      rev_in[i]  = a[N-1-i];
      rev_out[i] = stg[SW][N-1-i];
    end
  end

  assign fill   = right & arith & a[N-1];
  assign stg[0] = right ? a : rev_in;

  for (genvar s = 0; s < SW; s++) begin : g_stg
    assign stg[s+1] = shamt[s] ? {{(1 << s){fill}}, stg[s][N-1:(1 << s)]} : stg[s];
  end

  assign y = right ? stg[SW] : rev_out;
endmodule

module shift_exec_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);
  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [N-1:0] result;
    logic [4:0]   rd;
    logic         illegal;
  } res_t;

  typedef enum logic [1:0] {EMPTY, LOADED, FULL} state_t;

  state_t       state, state_nxt;
  res_t         out_q, skid_q, new_res;
  logic         acc, ld_out_new, ld_out_skid, ld_skid;
  logic         is_sll, is_sr, legal;
  logic [N-1:0] sh_y;
  logic         unused_b;

  assign unused_b = ^in_b[N-1:SW];

  assign is_sll = (in_funct3 == 3'b001);
  assign is_sr  = (in_funct3 == 3'b101);
  assign legal  = is_sll | is_sr;

  shift_barrel #(.N(N), .SW(SW)) u_shift (
    .a     (in_a),
    .shamt (in_b[SW-1:0]),
    .right (is_sr),
    .arith (in_funct7_5),
    .y     (sh_y)
  );

  always_comb begin
    new_res.result  = legal ? sh_y : '0;
    new_res.rd      = in_rd;
    new_res.illegal = ~legal;
  end

  // in_ready depends only on state and rst, never on out_ready.
  assign in_ready = (state != FULL) && !rst;
  assign acc      = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    ld_out_new  = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        ld_out_new = 1'b1;
        state_nxt  = LOADED;
      end
      LOADED: begin
        if (acc && out_ready) begin
          ld_out_new = 1'b1;
        end else if (acc) begin
          ld_skid   = 1'b1;
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (out_ready) begin
        ld_out_skid = 1'b1;
        state_nxt   = LOADED;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_q    <= '0;
      skid_q   <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (ld_out_new)       out_q <= new_res;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= new_res;
      if (acc)              op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_valid   = (state != EMPTY);
  assign out_result  = out_q.result;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;
endmodule
